// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues one outstanding word
// request to instruction memory and hands fetched words to decode via valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_jump,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] fetch_pc_r, fetch_pc_s;
    logic [31:0] req_pc_r, req_pc_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] pc_r, pc_s;
    logic        valid_r, valid_s;
    logic [31:0] hold_inst_r, hold_inst_s;
    logic [31:0] hold_pc_r, hold_pc_s;
    // Keeps the request low during reset and for the release cycle itself.
    logic        run_r;
    logic        slot_free_s;
    logic        consume_s;

    assign slot_free_s = !valid_r || inst_ready;
    assign consume_s   = valid_r && inst_ready;

    assign imem_req   = run_r && (state_r == S_REQ);
    assign imem_addr  = fetch_pc_r;
    assign inst_valid = valid_r;
    assign inst       = inst_r;
    assign pc         = pc_r;

    // Next-state and next-register values; redirect overrides everything else.
    always_comb begin
        state_s     = state_r;
        fetch_pc_s  = fetch_pc_r;
        req_pc_s    = req_pc_r;
        inst_s      = inst_r;
        pc_s        = pc_r;
        valid_s     = valid_r;
        hold_inst_s = hold_inst_r;
        hold_pc_s   = hold_pc_r;

        if (consume_s) begin
            valid_s = 1'b0;
            inst_s  = NOP_INST;
        end else begin
            valid_s = valid_r;
        end

        if (is_jump) begin
            fetch_pc_s  = jump_addr & 32'hFFFF_FFFC;
            valid_s     = 1'b0;
            inst_s      = NOP_INST;
            hold_inst_s = 32'h0000_0000;
            hold_pc_s   = 32'h0000_0000;
            case (state_r)
                S_REQ:   state_s = (imem_req && imem_ready) ? S_DROP : S_REQ;
                S_WAIT:  state_s = imem_rvalid ? S_REQ : S_DROP;
                S_HOLD:  state_s = S_REQ;
                S_DROP:  state_s = imem_rvalid ? S_REQ : S_DROP;
                default: state_s = S_REQ;
            endcase
        end else begin
            case (state_r)
                S_REQ: begin
                    if (imem_req && imem_ready) begin
                        req_pc_s = fetch_pc_r;
                        state_s  = S_WAIT;
                    end else begin
                        state_s = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid && slot_free_s) begin
                        inst_s     = imem_rdata;
                        pc_s       = req_pc_r;
                        valid_s    = 1'b1;
                        fetch_pc_s = next_word(req_pc_r);
                        state_s    = S_REQ;
                    end else if (imem_rvalid) begin
                        hold_inst_s = imem_rdata;
                        hold_pc_s   = req_pc_r;
                        fetch_pc_s  = next_word(req_pc_r);
                        state_s     = S_HOLD;
                    end else begin
                        state_s = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (slot_free_s) begin
                        inst_s  = hold_inst_r;
                        pc_s    = hold_pc_r;
                        valid_s = 1'b1;
                        state_s = S_REQ;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_s = S_REQ;
                    end else begin
                        state_s = S_DROP;
                    end
                end
                default: state_s = S_REQ;
            endcase
        end
    end

    // State, PC, output slot and hold buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_REQ;
            fetch_pc_r  <= RESET_PC;
            req_pc_r    <= RESET_PC;
            inst_r      <= NOP_INST;
            pc_r        <= RESET_PC;
            valid_r     <= 1'b0;
            hold_inst_r <= 32'h0000_0000;
            hold_pc_r   <= 32'h0000_0000;
            run_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            fetch_pc_r  <= fetch_pc_s;
            req_pc_r    <= req_pc_s;
            inst_r      <= inst_s;
            pc_r        <= pc_s;
            valid_r     <= valid_s;
            hold_inst_r <= hold_inst_s;
            hold_pc_r   <= hold_pc_s;
            run_r       <= 1'b1;
        end
    end

endmodule
